mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF stage (instruction fetch) and the ME stage (lw/sw).
- Grants one access at a time and sequences the fixed memory latency.
- Returns read data plus a one-cycle ready pulse to the owning requester.
- The pipeline stalls a stage while its `*_req & ~*_ready` holds. ME has priority, with anti-starvation for IF.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata. Legal range is 1..8; 1 means combinational-read memory.
- CNT_W, 3, latency counter width. Must satisfy 2^CNT_W ≥ MEM_LAT.

Ports:
- clock  in  1  system clock, rising edge.
- reset_0  in  1  asynchronous reset, active-low.
- if_req  in  1  fetch request. Held high until if_ready.
- if_addr  in  32  fetch byte address. Stable while if_req is high.
- if_rdata  out  32  fetched word. Valid in the if_ready cycle and held until the next IF read completes.
- if_ready  out  1  one-cycle completion pulse for IF.
- me_req  in  1  data request (rmem | wmem). Held high until me_ready.
- me_we  in  1  1 = store, 0 = load.
- me_addr  in  32  data byte address.
- me_wdata  in  32  store data.
- me_rdata  out  32  load data. Updated only by completed loads.
- me_ready  out  1  one-cycle completion pulse for ME.
- mem_en  out  1  memory access strobe. Exactly one cycle per access.
- mem_we  out  1  memory write enable. Qualified by mem_en.
- mem_addr  out  32  memory address. Held for the whole access.
- mem_wdata  out  32  memory write data. Held for the whole access.
- mem_rdata  in  32  memory read data. Valid MEM_LAT-1 cycles after the mem_en cycle.

Behaviour:
- Reset is reset_0, asynchronous, active-low; the clock is clock. Reset state of every output:
  - State is IDLE, cnt = 0, last_me = 0.
  - mem_en, mem_we, if_ready and me_ready are 0.
  - mem_addr, mem_wdata, if_rdata and me_rdata are 32'h0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The FSM has three states: IDLE, BUSY_IF, BUSY_ME.
- Request qualification: a request counts as pending only as `if_req & ~if_ready` (likewise `me_req & ~me_ready`). This masks the old request still visible during its own ready cycle.
- Arbitration in IDLE:
  - If both are pending and last_me = 1, grant IF; otherwise grant ME.
  - If only one is pending, grant it.
  - If none is pending, stay in IDLE.
- On a grant edge:
  - The state moves to BUSY_x and cnt loads MEM_LAT-1.
  - mem_en is set to 1 for the next cycle only.
  - mem_addr, mem_we and mem_wdata latch the granted requester's values. For an IF grant, mem_we = 0 and mem_wdata = 0.
  - last_me is set to 1 for an ME grant and 0 for an IF grant.
- In BUSY_x:
  - mem_en drops after the first cycle. mem_addr, mem_we and mem_wdata stay constant.
  - cnt decrements each cycle while nonzero.
  - In the cycle with cnt == 0, mem_rdata is sampled at the closing edge into if_rdata (BUSY_IF) or into me_rdata (BUSY_ME, only when mem_we = 0).
  - At that same edge the matching ready is set to 1 for one cycle and the state returns to IDLE.
- Latency: request first pending in cycle t → mem_en in cycle t+1 → ready in cycle t+1+MEM_LAT. Back-to-back throughput is one access per MEM_LAT+1 cycles.
- A new grant may be issued in the same IDLE cycle in which the other requester's ready is high.
- Simultaneous requests are settled by the last_me rule. IF is never starved for more than one ME access.
- Dropping a request while BUSY does not abort the access. The access completes and ready still pulses.
- A reset during BUSY aborts immediately to IDLE, discards the in-flight access, and produces no ready pulse.
- The counter never wraps: cnt stays at 0 when the state is not BUSY.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants: ST_IDLE = 2'd0, ST_BUSY_IF = 2'd1, ST_BUSY_ME = 2'd2;
  - default MEM_LAT;
  - CNT_W derivation.
- One natural sub-module, mem_lat_counter: a loadable down-counter with a zero flag (inputs load, value; output is_zero). The FSM and datapath latches stay in the top.

Test Plan:
- IF-only read, MEM_LAT=2, memory returns 32'h2008_0005 for address 0x40. if_req rises in cycle 0 → mem_en=1, mem_addr=0x40, mem_we=0 in cycle 1 only; if_ready=1 in cycle 3 with if_rdata=32'h2008_0005.
- ME store: me_req=1, me_we=1, me_addr=0x100, me_wdata=32'hDEAD_BEEF → mem_we=1 with mem_en in cycle 1; me_ready in cycle 3; me_rdata unchanged.
- if_req and me_req both rise in cycle 0 after reset (last_me=0) → ME granted first, me_ready in cycle 3; IF granted in cycle 3 with mem_en in cycle 4 and if_ready in cycle 6.
- Both held continuously for 4 accesses → grant order ME, IF, ME, IF; ready pulses every 3 cycles; no extra pulses.
- reset_0 driven low in cycle 2 of a BUSY_IF access → outputs go immediately to reset values; no if_ready; after release, a fresh if_req completes normally.
- MEM_LAT=1 build: me load at 0x8 with mem_rdata=32'h1234 valid combinationally in the mem_en cycle → me_ready in cycle 2 with me_rdata=32'h1234.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/ME unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned MEM_LAT_DEFAULT = 2;
    localparam int unsigned CNT_W_DEFAULT   = 3;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_ME = 2'd2
    } arb_state_e;

    // Memory command latched at grant and held for the whole access
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Smallest counter width that can hold MEM_LAT-1 (at least one bit)
    function automatic int unsigned cnt_w_for(input int unsigned lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that sequences the fixed memory latency; saturates at zero.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] value,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt;

    // Load on grant, otherwise count down while busy and never wrap below zero
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch (IF)
// and load/store (ME). ME wins ties unless it also won the previous access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              me_req,
    input  logic              me_we,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [DATA_W-1:0] me_wdata,
    output logic [DATA_W-1:0] me_rdata,
    output logic              me_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Widen the counter if the parameters disagree so MEM_LAT-1 always fits
    localparam int unsigned CNT_WIDTH =
        (CNT_W >= cnt_w_for(MEM_LAT)) ? CNT_W : cnt_w_for(MEM_LAT);
    localparam logic [CNT_WIDTH-1:0] LAT_LOAD = CNT_WIDTH'(MEM_LAT - 1);

    arb_state_e        state, state_d;
    logic              last_me, last_me_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic              mem_en_d, if_ready_d, me_ready_d;
    logic [DATA_W-1:0] if_rdata_d, me_rdata_d;
    logic              cnt_load, cnt_zero;
    logic              if_pend, me_pend;

    // A requester whose ready is high this cycle is still showing its old request
    assign if_pend = if_req & ~if_ready;
    assign me_pend = me_req & ~me_ready;

    mem_lat_counter #(
        .CNT_W (CNT_WIDTH)
    ) u_lat_cnt (
        .clock   (clock),
        .reset_0 (reset_0),
        .load    (cnt_load),
        .dec     (state != ST_IDLE),
        .value   (LAT_LOAD),
        .is_zero (cnt_zero)
    );

    // State and output registers
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state    <= ST_IDLE;
            last_me  <= 1'b0;
            cmd_q    <= '0;
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            me_ready <= 1'b0;
            if_rdata <= '0;
            me_rdata <= '0;
        end else begin
            state    <= state_d;
            last_me  <= last_me_d;
            cmd_q    <= cmd_d;
            mem_en   <= mem_en_d;
            if_ready <= if_ready_d;
            me_ready <= me_ready_d;
            if_rdata <= if_rdata_d;
            me_rdata <= me_rdata_d;
        end
    end

    // Arbitration, access sequencing and next values of the registered outputs
    always_comb begin
        state_d    = state;
        last_me_d  = last_me;
        cmd_d      = cmd_q;
        mem_en_d   = 1'b0;
        if_ready_d = 1'b0;
        me_ready_d = 1'b0;
        if_rdata_d = if_rdata;
        me_rdata_d = me_rdata;
        cnt_load   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (me_pend && !(if_pend && last_me)) begin
                    state_d     = ST_BUSY_ME;
                    last_me_d   = 1'b1;
                    cnt_load    = 1'b1;
                    mem_en_d    = 1'b1;
                    cmd_d.we    = me_we;
                    cmd_d.addr  = me_addr;
                    cmd_d.wdata = me_wdata;
                end else if (if_pend) begin
                    state_d     = ST_BUSY_IF;
                    last_me_d   = 1'b0;
                    cnt_load    = 1'b1;
                    mem_en_d    = 1'b1;
                    cmd_d.we    = 1'b0;
                    cmd_d.addr  = if_addr;
                    cmd_d.wdata = '0;
                end
            end
            ST_BUSY_IF: begin
                if (cnt_zero) begin
                    if_rdata_d = mem_rdata;
                    if_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_BUSY_ME: begin
                if (cnt_zero) begin
                    if (!cmd_q.we) begin
                        me_rdata_d = mem_rdata;
                    end
                    me_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset/MEM_LAT=1 corner
// sequences and a randomized run against a transaction-level schedule model.
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 2;
    localparam logic [31:0] S40 = 32'h2008_0005;
    localparam logic [31:0] S44 = 32'hC0DE_0011;
    localparam logic [31:0] S48 = 32'hC0DE_0012;
    localparam logic [31:0] S80 = 32'hC0DE_0020;
    localparam logic [31:0] W   = 32'h5555_AAAA;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset_0;
    logic        if_req, me_req, me_we;
    logic [31:0] if_addr, me_addr, me_wdata, mem_rdata;
    logic [31:0] if_rdata, me_rdata, mem_addr, mem_wdata;
    logic        if_ready, me_ready, mem_en, mem_we;

    logic        if_req1, me_req1, me_we1;
    logic [31:0] if_addr1, me_addr1, me_wdata1, mem_rdata1;
    logic [31:0] if_rdata1, me_rdata1, mem_addr1, mem_wdata1;
    logic        if_ready1, me_ready1, mem_en1, mem_we1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.MEM_LAT(LAT), .CNT_W(3)) dut (
        .clock(clock), .reset_0(reset_0),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .me_req(me_req), .me_we(me_we), .me_addr(me_addr), .me_wdata(me_wdata),
        .me_rdata(me_rdata), .me_ready(me_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(1), .CNT_W(1)) dut1 (
        .clock(clock), .reset_0(reset_0),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
        .me_req(me_req1), .me_we(me_we1), .me_addr(me_addr1), .me_wdata(me_wdata1),
        .me_rdata(me_rdata1), .me_ready(me_ready1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    // Initial memory contents, indexed by word address bits [9:2]
    function automatic logic [31:0] seed(input logic [7:0] i);
        return (i == 8'd16) ? S40 : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Memory device for the MEM_LAT=2 instance: data valid only in the cycle after mem_en
    logic [31:0] dev_mem [256];
    bit          dev_wv  [256];
    always @(posedge clock) begin
        if (mem_en && mem_we) begin
            dev_mem[mem_addr[9:2]] <= mem_wdata;
            dev_wv[mem_addr[9:2]]  <= 1'b1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= dev_wv[mem_addr[9:2]] ? dev_mem[mem_addr[9:2]] : seed(mem_addr[9:2]);
        else
            mem_rdata <= 32'hBAD0_0BAD;
    end

    // Combinational-read memory for the MEM_LAT=1 instance
    assign mem_rdata1 = (mem_en1 && mem_addr1 == 32'h8) ? 32'h0000_1234 : 32'hBAD1_BAD1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ir;  logic [31:0] ia;
        logic        mr;  logic        mw; logic [31:0] ma; logic [31:0] md;
        logic        en;  logic        we; logic [31:0] a;  logic [31:0] wd;
        logic        irdy; logic [31:0] ird;
        logic        mrdy; logic [31:0] mrd;
    } vec_t;

    function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic mr,
                               input logic mw, input logic [31:0] ma, input logic [31:0] md,
                               input logic en, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic irdy, input logic [31:0] ird,
                               input logic mrdy, input logic [31:0] mrd);
        vec_t r;
        r.ir = ir; r.ia = ia; r.mr = mr; r.mw = mw; r.ma = ma; r.md = md;
        r.en = en; r.we = we; r.a = a; r.wd = wd;
        r.irdy = irdy; r.ird = ird; r.mrdy = mrdy; r.mrd = mrd;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"},    32'(mem_en),   32'h0);
        check({tag, "_mem_we"},    32'(mem_we),   32'h0);
        check({tag, "_if_ready"},  32'(if_ready), 32'h0);
        check({tag, "_me_ready"},  32'(me_ready), 32'h0);
        check({tag, "_mem_addr"},  mem_addr,      32'h0);
        check({tag, "_mem_wdata"}, mem_wdata,     32'h0);
        check({tag, "_if_rdata"},  if_rdata,      32'h0);
        check({tag, "_me_rdata"},  me_rdata,      32'h0);
    endtask

    // Randomized-run reference state
    logic [31:0] ref_mem [256];
    bit          ref_wv  [256];
    bit          m_busy, m_own_me, m_last_me;
    int          m_en_cyc, m_done;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_me_rd, n_addr, n_wdata, n_rd;
    logic        m_we, n_we;

    initial begin
        vec_t tbl[$];
        bit   e_en, e_ir, e_mr, pi, pm, if_seen, me_seen;

        reset_0 = 1'b0;
        {if_req, me_req, me_we} = '0; {if_addr, me_addr, me_wdata} = '0;
        {if_req1, me_req1, me_we1} = '0; {if_addr1, me_addr1, me_wdata1} = '0;

        tbl.push_back(v(1,'h40,0,0,0,0,       0,0,0,0,         0,0,  0,0));
        tbl.push_back(v(1,'h40,0,0,0,0,       1,0,'h40,0,      0,0,  0,0));
        tbl.push_back(v(1,'h40,0,0,0,0,       0,0,'h40,0,      0,0,  0,0));
        tbl.push_back(v(1,'h40,0,0,0,0,       0,0,'h40,0,      1,S40,0,0));
        tbl.push_back(v(0,0,0,0,0,0,          0,0,'h40,0,      0,S40,0,0));
        tbl.push_back(v(1,'h44,1,0,'h80,W,    0,0,'h40,0,      0,S40,0,0));
        tbl.push_back(v(1,'h44,1,0,'h80,W,    1,0,'h80,W,      0,S40,0,0));
        tbl.push_back(v(1,'h44,1,0,'h80,W,    0,0,'h80,W,      0,S40,0,0));
        tbl.push_back(v(1,'h44,1,0,'h80,W,    0,0,'h80,W,      0,S40,1,S80));
        tbl.push_back(v(1,'h44,1,0,'h80,W,    1,0,'h44,0,      0,S40,0,S80));
        tbl.push_back(v(1,'h44,1,0,'h80,W,    0,0,'h44,0,      0,S40,0,S80));
        tbl.push_back(v(1,'h44,1,0,'h80,W,    0,0,'h44,0,      1,S44,0,S80));
        tbl.push_back(v(1,'h44,1,0,'h80,W,    1,0,'h80,W,      0,S44,0,S80));
        tbl.push_back(v(1,'h44,1,0,'h80,W,    0,0,'h80,W,      0,S44,0,S80));
        tbl.push_back(v(1,'h44,1,0,'h80,W,    0,0,'h80,W,      0,S44,1,S80));
        tbl.push_back(v(1,'h44,0,0,0,0,       1,0,'h44,0,      0,S44,0,S80));
        tbl.push_back(v(1,'h44,0,0,0,0,       0,0,'h44,0,      0,S44,0,S80));
        tbl.push_back(v(1,'h44,0,0,0,0,       0,0,'h44,0,      1,S44,0,S80));
        tbl.push_back(v(0,0,0,0,0,0,          0,0,'h44,0,      0,S44,0,S80));
        tbl.push_back(v(0,0,1,1,'h100,DB,     0,0,'h44,0,      0,S44,0,S80));
        tbl.push_back(v(0,0,1,1,'h100,DB,     1,1,'h100,DB,    0,S44,0,S80));
        tbl.push_back(v(0,0,1,1,'h100,DB,     0,1,'h100,DB,    0,S44,0,S80));
        tbl.push_back(v(0,0,1,1,'h100,DB,     0,1,'h100,DB,    0,S44,1,S80));
        tbl.push_back(v(0,0,0,0,0,0,          0,1,'h100,DB,    0,S44,0,S80));
        tbl.push_back(v(1,'h100,0,0,0,0,      0,1,'h100,DB,    0,S44,0,S80));
        tbl.push_back(v(1,'h100,0,0,0,0,      1,0,'h100,0,     0,S44,0,S80));
        tbl.push_back(v(1,'h100,0,0,0,0,      0,0,'h100,0,     0,S44,0,S80));
        tbl.push_back(v(1,'h100,0,0,0,0,      0,0,'h100,0,     1,DB, 0,S80));
        tbl.push_back(v(0,0,0,0,0,0,          0,0,'h100,0,     0,DB, 0,S80));

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst");
        reset_0 = 1'b1;

        // Directed vector table, one row per cycle
        foreach (tbl[k]) begin
            @(posedge clock); #1;
            if_req = tbl[k].ir; if_addr = tbl[k].ia;
            me_req = tbl[k].mr; me_we = tbl[k].mw; me_addr = tbl[k].ma; me_wdata = tbl[k].md;
            @(negedge clock);
            check($sformatf("vec%0d_mem_en", k),    32'(mem_en),   32'(tbl[k].en));
            check($sformatf("vec%0d_mem_we", k),    32'(mem_we),   32'(tbl[k].we));
            check($sformatf("vec%0d_mem_addr", k),  mem_addr,      tbl[k].a);
            check($sformatf("vec%0d_mem_wdata", k), mem_wdata,     tbl[k].wd);
            check($sformatf("vec%0d_if_ready", k),  32'(if_ready), 32'(tbl[k].irdy));
            check($sformatf("vec%0d_if_rdata", k),  if_rdata,      tbl[k].ird);
            check($sformatf("vec%0d_me_ready", k),  32'(me_ready), 32'(tbl[k].mrdy));
            check($sformatf("vec%0d_me_rdata", k),  me_rdata,      tbl[k].mrd);
        end

        // Reset in the middle of an IF access: immediate clear, no ready afterwards
        @(posedge clock); #1; if_req = 1'b1; if_addr = 32'h48;
        @(negedge clock); check("abort_c0_mem_en", 32'(mem_en), 32'h0);
        @(posedge clock); #1;
        @(negedge clock);
        check("abort_c1_mem_en", 32'(mem_en), 32'h1);
        check("abort_c1_mem_addr", mem_addr, 32'h48);
        @(posedge clock); #2; reset_0 = 1'b0; if_req = 1'b0; #1;
        check_reset_outputs("abort");
        @(posedge clock); #2; reset_0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("abort_idle%0d_if_ready", i), 32'(if_ready), 32'h0);
            check($sformatf("abort_idle%0d_mem_en", i),   32'(mem_en),   32'h0);
        end
        @(posedge clock); #1; if_req = 1'b1; if_addr = 32'h48;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("fresh%0d_mem_en", i),   32'(mem_en),   32'(i == 1));
            check($sformatf("fresh%0d_if_ready", i), 32'(if_ready), 32'(i == 3));
            @(posedge clock); #1;
        end
        if_req = 1'b0;
        check("fresh_if_rdata", if_rdata, S48);

        // MEM_LAT=1 instance: load served in the mem_en cycle, ready one cycle later
        me_req1 = 1'b1; me_we1 = 1'b0; me_addr1 = 32'h8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("lat1_c%0d_mem_en", i),   32'(mem_en1),   32'(i == 1));
            check($sformatf("lat1_c%0d_me_ready", i), 32'(me_ready1), 32'(i == 2));
            if (i == 1) check("lat1_mem_addr", mem_addr1, 32'h8);
            @(posedge clock); #1;
            if (i == 2) me_req1 = 1'b0;
        end
        check("lat1_me_rdata", me_rdata1, 32'h0000_1234);

        // Randomized traffic against a grant/completion schedule model
        m_busy = 0; m_last_me = 0; m_en_cyc = -1; m_done = -1; m_own_me = 0;
        m_addr = 32'h48; m_we = 1'b0; m_wdata = '0; m_if_rd = S48; m_me_rd = '0;
        n_addr = '0; n_we = 1'b0; n_wdata = '0; n_rd = '0;
        ref_wv[64] = 1'b1; ref_mem[64] = DB;
        if_seen = 0; me_seen = 0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clock); #1;
            if ((if_req && if_seen && $urandom_range(0, 1) == 0) ||
                (!if_req && $urandom_range(0, 2) == 0)) begin
                if_req = 1'b1; if_addr = 32'($urandom_range(60, 75)) << 2;
            end else if (if_req && if_seen) begin
                if_req = 1'b0;
            end
            if ((me_req && me_seen && $urandom_range(0, 1) == 0) ||
                (!me_req && $urandom_range(0, 2) == 0)) begin
                me_req = 1'b1; me_we = 1'($urandom_range(0, 1));
                me_addr = 32'($urandom_range(60, 75)) << 2; me_wdata = $urandom;
            end else if (me_req && me_seen) begin
                me_req = 1'b0;
            end
            @(negedge clock);
            e_en = m_busy && (c == m_en_cyc);
            e_ir = m_busy && (c == m_done) && !m_own_me;
            e_mr = m_busy && (c == m_done) && m_own_me;
            if (e_en) begin m_addr = n_addr; m_we = n_we; m_wdata = n_wdata; end
            if (e_ir) m_if_rd = n_rd;
            if (e_mr && !m_we) m_me_rd = n_rd;
            check($sformatf("rnd%0d_mem_en", c),    32'(mem_en),   32'(e_en));
            check($sformatf("rnd%0d_if_ready", c),  32'(if_ready), 32'(e_ir));
            check($sformatf("rnd%0d_me_ready", c),  32'(me_ready), 32'(e_mr));
            check($sformatf("rnd%0d_mem_addr", c),  mem_addr,      m_addr);
            check($sformatf("rnd%0d_mem_we", c),    32'(mem_we),   32'(m_we));
            check($sformatf("rnd%0d_mem_wdata", c), mem_wdata,     m_wdata);
            check($sformatf("rnd%0d_if_rdata", c),  if_rdata,      m_if_rd);
            check($sformatf("rnd%0d_me_rdata", c),  me_rdata,      m_me_rd);
            if_seen = if_ready; me_seen = me_ready;
            if (m_busy && c == m_done) m_busy = 0;
            pi = if_req && !e_ir;
            pm = me_req && !e_mr;
            if (!m_busy && (pi || pm)) begin
                m_own_me  = pm && !(pi && m_last_me);
                m_last_me = m_own_me;
                n_addr  = m_own_me ? me_addr  : if_addr;
                n_we    = m_own_me ? me_we    : 1'b0;
                n_wdata = m_own_me ? me_wdata : 32'h0;
                if (n_we) begin
                    ref_mem[n_addr[9:2]] = n_wdata; ref_wv[n_addr[9:2]] = 1'b1;
                end else begin
                    n_rd = ref_wv[n_addr[9:2]] ? ref_mem[n_addr[9:2]] : seed(n_addr[9:2]);
                end
                m_busy = 1; m_en_cyc = c + 1; m_done = c + 1 + int'(LAT);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
